// File: rtl/fifo_serial_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_serial_tx: drains a show-ahead FIFO, sends each byte as an async serial frame
// Rev 1.0
// ----------------------------------------------------------------------------
module fifo_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_dout_i,
  output logic              fifo_pop_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tx_d       = tx_q;
    fifo_pop_o = 1'b0;
    bit_end    = (clk_cnt_q == CNT_LAST);

    // Every non-idle state spends CLKS_PER_BIT cycles per serial bit.
    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Gated by reset so the FIFO never sees a pop while held in reset.
        fifo_pop_o = en_i & ~fifo_empty_i & rst_ni;
        if (fifo_pop_o) begin
          shreg_d   = fifo_dout_i;
          par_d     = ^fifo_dout_i;
          tx_d      = 1'b0;
          state_d   = S_START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_serial_tx.sv
`default_nettype none
// Bench for fifo_serial_tx: a plain instance and an even-parity instance, each checked
// every cycle against a frame-level model, plus literal pins on key timing points.
module tb_fifo_serial_tx;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;
  always #5 clk = ~clk;

  // Show-ahead FIFO stand-ins: pushes come from the stimulus, pops from the DUT.
  logic [7:0] mem0 [0:31];
  logic [7:0] mem1 [0:31];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  logic       empty0, empty1;
  logic [7:0] dout0, dout1;
  logic       pop0, pop1, tx0, tx1, busy0, busy1;

  assign empty0 = (rd0 >= wr0);
  assign empty1 = (rd1 >= wr1);
  assign dout0  = empty0 ? 8'h5A : mem0[rd0[4:0]];
  assign dout1  = empty1 ? 8'h5A : mem1[rd1[4:0]];

  always @(posedge clk) begin
    if (pop0) rd0 <= rd0 + 1;
    if (pop1) rd1 <= rd1 + 1;
  end

  fifo_serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .fifo_empty_i(empty0), .fifo_dout_i(dout0),
    .fifo_pop_o(pop0), .tx_o(tx0), .busy_o(busy0)
  );

  fifo_serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .fifo_empty_i(empty1), .fifo_dout_i(dout1),
    .fifo_pop_o(pop1), .tx_o(tx1), .busy_o(busy1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: a frame is a list of line bits, each held CPB cycles; idle line is 1.
  logic        act    [2] = '{default: 1'b0};
  int          el     [2] = '{default: 0};
  int          tot    [2] = '{default: 0};
  logic [15:0] fb     [2] = '{default: '1};
  int          popcnt [2] = '{default: 0};
  int          lastpop[2] = '{default: 0};
  int          popgap [2] = '{default: 0};
  int          run    [2] = '{default: 0};
  int          blen   [2] = '{default: 0};

  int lit_req = 0, lit_ack = 0, lit_code = 0, lit_exp = 0;

  task automatic cmp(input string nm, input int k, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", nm, k, cyc, act_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    logic       a_pop, a_tx, a_busy, e_pop, e_tx, e_busy, emp;
    logic [7:0] d;
    int         pv, nb;
    string      pn;
    for (int k = 0; k < 2; k++) begin
      a_pop  = (k == 0) ? pop0   : pop1;
      a_tx   = (k == 0) ? tx0    : tx1;
      a_busy = (k == 0) ? busy0  : busy1;
      emp    = (k == 0) ? empty0 : empty1;
      d      = (k == 0) ? dout0  : dout1;
      if (!rst_n) begin
        act[k] = 1'b0;
        e_pop  = 1'b0;
        e_tx   = 1'b1;
        e_busy = 1'b0;
      end else begin
        e_busy = act[k];
        e_tx   = act[k] ? fb[k][el[k] / CPB] : 1'b1;
        e_pop  = !act[k] && en && !emp;
      end
      cmp("pop",  k, int'(a_pop),  int'(e_pop));
      cmp("tx",   k, int'(a_tx),   int'(e_tx));
      cmp("busy", k, int'(a_busy), int'(e_busy));
      if (rst_n) begin
        if (act[k]) begin
          el[k]++;
          if (el[k] == tot[k]) act[k] = 1'b0;
        end else if (e_pop) begin
          fb[k]      = '1;
          fb[k][0]   = 1'b0;
          fb[k][8:1] = d;
          nb = 10;
          if (k == 1) begin
            fb[k][9] = ^d;
            nb = 11;
          end
          tot[k] = nb * CPB;
          el[k]  = 0;
          act[k] = 1'b1;
        end
      end
      if (a_pop) begin
        popcnt[k]++;
        popgap[k]  = cyc - lastpop[k];
        lastpop[k] = cyc;
      end
      if (a_busy) run[k]++;
      else if (run[k] != 0) begin
        blen[k] = run[k];
        run[k]  = 0;
      end
    end
    if (lit_req != lit_ack) begin
      lit_ack = lit_req;
      case (lit_code)
        0: begin pv = int'(tx0);   pn = "pin_tx0";      end
        1: begin pv = int'(busy0); pn = "pin_busy0";    end
        2: begin pv = int'(pop0);  pn = "pin_pop0";     end
        3: begin pv = int'(tx1);   pn = "pin_tx1";      end
        4: begin pv = blen[0];     pn = "pin_busylen0"; end
        5: begin pv = blen[1];     pn = "pin_busylen1"; end
        6: begin pv = popgap[0];   pn = "pin_popgap0";  end
        default: begin pv = popcnt[0]; pn = "pin_popcnt0"; end
      endcase
      cmp(pn, 0, pv, lit_exp);
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Literal expectation checked at the next falling edge; consumes one cycle.
  task automatic pin(input int code, input int exp_v);
    lit_code = code;
    lit_exp  = exp_v;
    lit_req++;
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] b);
    mem0[wr0[4:0]] = b;
    wr0++;
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wr1[4:0]] = b;
    wr1++;
  endtask

  logic [9:0] exp_a5 = 10'b1101001010;

  initial begin
    // Reset with data waiting and en=1
    push0(8'h3C);
    tick(2);
    pin(0, 1);
    pin(1, 0);
    pin(2, 0);
    rst_n = 1'b1;
    pin(2, 1);
    tick(45);
    pin(1, 0);

    // Single byte 0xA5, mid-bit literal samples
    push0(8'hA5);
    tick(1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pin(0, int'(exp_a5[i]));
      tick(2);
    end
    pin(4, 40);
    tick(5);
    pin(2, 0);
    pin(7, 2);

    // Back-to-back 0x00, 0xFF
    push0(8'h00);
    push0(8'hFF);
    tick(41);
    pin(0, 1);
    pin(0, 0);
    tick(45);
    pin(6, 41);

    // Even parity instance
    push1(8'h07);
    tick(38);
    pin(3, 1);
    tick(6);
    pin(5, 44);
    push1(8'h03);
    tick(38);
    pin(3, 0);
    tick(10);

    // en dropped mid-frame with three bytes queued
    push0(8'h11);
    push0(8'h22);
    push0(8'h33);
    tick(10);
    en = 1'b0;
    tick(31);
    pin(2, 0);
    tick(20);
    en = 1'b1;
    pin(2, 1);
    tick(90);
    pin(7, 7);

    // Reset pulse during DATA bit 3 (bit value 0 so the forced 1 is visible)
    push0(8'h35);
    push0(8'hC3);
    tick(18);
    rst_n = 1'b0;
    pin(0, 1);
    pin(1, 0);
    rst_n = 1'b1;
    pin(2, 1);
    pin(6, 20);
    tick(50);
    pin(7, 9);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
